// File: rtl/panda_risc_v_reg_file_rd_arb_if.sv
// panda_risc_v_reg_file_rd_arb_if: requester, physical read port and perf signals of the register file read arbiter
interface panda_risc_v_reg_file_rd_arb_if #(
    parameter int CONFLICT_CNT_W = 16
);
    logic                      dcd_reg_file_rd_p0_req;
    logic [4:0]                dcd_reg_file_rd_p0_addr;
    logic                      dcd_reg_file_rd_p0_grant;
    logic [31:0]               dcd_reg_file_rd_p0_dout;
    logic                      dcd_reg_file_rd_p1_req;
    logic [4:0]                dcd_reg_file_rd_p1_addr;
    logic                      dcd_reg_file_rd_p1_grant;
    logic [31:0]               dcd_reg_file_rd_p1_dout;
    logic                      aux_reg_file_rd_p0_req;
    logic [4:0]                aux_reg_file_rd_p0_addr;
    logic                      aux_reg_file_rd_p0_grant;
    logic [31:0]               aux_reg_file_rd_p0_dout;
    logic                      aux_reg_file_rd_p1_req;
    logic [4:0]                aux_reg_file_rd_p1_addr;
    logic                      aux_reg_file_rd_p1_grant;
    logic [31:0]               aux_reg_file_rd_p1_dout;
    logic                      reg_file_rd_p0_en;
    logic [4:0]                reg_file_rd_p0_addr;
    logic [31:0]               reg_file_rd_p0_dout;
    logic                      reg_file_rd_p1_en;
    logic [4:0]                reg_file_rd_p1_addr;
    logic [31:0]               reg_file_rd_p1_dout;
    logic                      perf_conflict_clr;
    logic [CONFLICT_CNT_W-1:0] perf_conflict_cnt;

    modport master (
        output dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
        output dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
        output aux_reg_file_rd_p0_req, aux_reg_file_rd_p0_addr,
        output aux_reg_file_rd_p1_req, aux_reg_file_rd_p1_addr,
        output reg_file_rd_p0_dout, reg_file_rd_p1_dout, perf_conflict_clr,
        input  dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
        input  dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
        input  aux_reg_file_rd_p0_grant, aux_reg_file_rd_p0_dout,
        input  aux_reg_file_rd_p1_grant, aux_reg_file_rd_p1_dout,
        input  reg_file_rd_p0_en, reg_file_rd_p0_addr,
        input  reg_file_rd_p1_en, reg_file_rd_p1_addr, perf_conflict_cnt
    );

    modport slave (
        input  dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
        input  dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
        input  aux_reg_file_rd_p0_req, aux_reg_file_rd_p0_addr,
        input  aux_reg_file_rd_p1_req, aux_reg_file_rd_p1_addr,
        input  reg_file_rd_p0_dout, reg_file_rd_p1_dout, perf_conflict_clr,
        output dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
        output dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
        output aux_reg_file_rd_p0_grant, aux_reg_file_rd_p0_dout,
        output aux_reg_file_rd_p1_grant, aux_reg_file_rd_p1_dout,
        output reg_file_rd_p0_en, reg_file_rd_p0_addr,
        output reg_file_rd_p1_en, reg_file_rd_p1_addr, perf_conflict_cnt
    );
endinterface

// File: rtl/panda_risc_v_reg_file_rd_arb.sv
// panda_risc_v_reg_file_rd_arb: decoder-first arbiter with aux starvation guard for the two register file read ports
module panda_risc_v_reg_file_rd_arb #(
    parameter int STARVE_LIMIT   = 4,
    parameter int CONFLICT_CNT_W = 16
) (
    input logic clk,
    input logic rst,
    panda_risc_v_reg_file_rd_arb_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]       d_req, a_req, d_gnt, a_gnt, en, conflict;
    logic [1:0][4:0]  d_addr, a_addr, ph_addr;
    logic [1:0][31:0] rf_dout, d_dout, a_dout;
    logic [CONFLICT_CNT_W-1:0] cnt;

    assign d_req   = {bus.dcd_reg_file_rd_p1_req, bus.dcd_reg_file_rd_p0_req};
    assign a_req   = {bus.aux_reg_file_rd_p1_req, bus.aux_reg_file_rd_p0_req};
    assign d_addr  = {bus.dcd_reg_file_rd_p1_addr, bus.dcd_reg_file_rd_p0_addr};
    assign a_addr  = {bus.aux_reg_file_rd_p1_addr, bus.aux_reg_file_rd_p0_addr};
    assign rf_dout = {bus.reg_file_rd_p1_dout, bus.reg_file_rd_p0_dout};

    for (genvar k = 0; k < 2; k++) begin : g_port
        logic       d_real, a_real, aux_win, d_use, a_use;
        logic [3:0] starve;
        assign d_real      = d_req[k] && d_addr[k] != 5'd0;
        assign a_real      = a_req[k] && a_addr[k] != 5'd0;
        assign conflict[k] = d_real && a_real && d_addr[k] != a_addr[k];
        assign aux_win     = conflict[k] && starve == LIMIT;
        // x0 reads never lose: only a different-address conflict can deny a requester
        assign d_gnt[k]    = d_req[k] && !aux_win;
        assign a_gnt[k]    = a_req[k] && (!conflict[k] || aux_win);
        assign d_use       = d_real && d_gnt[k];
        assign a_use       = a_real && a_gnt[k];
        assign en[k]       = d_use || a_use;
        assign ph_addr[k]  = d_use ? d_addr[k] : a_use ? a_addr[k] : 5'd0;
        assign d_dout[k]   = d_use ? rf_dout[k] : 32'h0;
        assign a_dout[k]   = a_use ? rf_dout[k] : 32'h0;
        always_ff @(posedge clk or posedge rst)
            if (rst) starve <= 4'd0;
            else starve <= (!a_real || a_gnt[k]) ? 4'd0 : (starve == LIMIT) ? starve : starve + 4'd1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= bus.perf_conflict_clr ? '0 : cnt + CONFLICT_CNT_W'((|conflict) && cnt != '1);

    assign bus.dcd_reg_file_rd_p0_grant = d_gnt[0];
    assign bus.dcd_reg_file_rd_p1_grant = d_gnt[1];
    assign bus.aux_reg_file_rd_p0_grant = a_gnt[0];
    assign bus.aux_reg_file_rd_p1_grant = a_gnt[1];
    assign bus.dcd_reg_file_rd_p0_dout  = d_dout[0];
    assign bus.dcd_reg_file_rd_p1_dout  = d_dout[1];
    assign bus.aux_reg_file_rd_p0_dout  = a_dout[0];
    assign bus.aux_reg_file_rd_p1_dout  = a_dout[1];
    assign bus.reg_file_rd_p0_en        = en[0];
    assign bus.reg_file_rd_p1_en        = en[1];
    assign bus.reg_file_rd_p0_addr      = ph_addr[0];
    assign bus.reg_file_rd_p1_addr      = ph_addr[1];
    assign bus.perf_conflict_cnt        = cnt;
endmodule

// File: tb/tb_panda_risc_v_reg_file_rd_arb.sv
// tb_panda_risc_v_reg_file_rd_arb: directed and random checks of the read arbiter against a behavioural model
module tb_panda_risc_v_reg_file_rd_arb;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       dreq [2];
    logic       areq [2];
    logic [4:0] da [2];
    logic [4:0] aa [2];
    logic       clr;

    panda_risc_v_reg_file_rd_arb_if #(.CONFLICT_CNT_W(16)) a_if ();
    panda_risc_v_reg_file_rd_arb_if #(.CONFLICT_CNT_W(4))  b_if ();

    panda_risc_v_reg_file_rd_arb #(.STARVE_LIMIT(L), .CONFLICT_CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(a_if));
    panda_risc_v_reg_file_rd_arb #(.STARVE_LIMIT(L), .CONFLICT_CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(b_if));

    function automatic logic [31:0] rf(input logic [4:0] a);
        return {16'hA5A5, 11'd0, a};
    endfunction

    assign a_if.dcd_reg_file_rd_p0_req  = dreq[0];
    assign a_if.dcd_reg_file_rd_p1_req  = dreq[1];
    assign a_if.aux_reg_file_rd_p0_req  = areq[0];
    assign a_if.aux_reg_file_rd_p1_req  = areq[1];
    assign a_if.dcd_reg_file_rd_p0_addr = da[0];
    assign a_if.dcd_reg_file_rd_p1_addr = da[1];
    assign a_if.aux_reg_file_rd_p0_addr = aa[0];
    assign a_if.aux_reg_file_rd_p1_addr = aa[1];
    assign a_if.perf_conflict_clr       = clr;
    assign a_if.reg_file_rd_p0_dout     = rf(a_if.reg_file_rd_p0_addr);
    assign a_if.reg_file_rd_p1_dout     = rf(a_if.reg_file_rd_p1_addr);
    assign b_if.reg_file_rd_p0_dout     = rf(b_if.reg_file_rd_p0_addr);
    assign b_if.reg_file_rd_p1_dout     = rf(b_if.reg_file_rd_p1_addr);

    logic        o_dg [2];
    logic        o_ag [2];
    logic        o_en [2];
    logic [4:0]  o_addr [2];
    logic [31:0] o_dd [2];
    logic [31:0] o_ad [2];
    assign o_dg[0] = a_if.dcd_reg_file_rd_p0_grant;
    assign o_dg[1] = a_if.dcd_reg_file_rd_p1_grant;
    assign o_ag[0] = a_if.aux_reg_file_rd_p0_grant;
    assign o_ag[1] = a_if.aux_reg_file_rd_p1_grant;
    assign o_en[0] = a_if.reg_file_rd_p0_en;
    assign o_en[1] = a_if.reg_file_rd_p1_en;
    assign o_addr[0] = a_if.reg_file_rd_p0_addr;
    assign o_addr[1] = a_if.reg_file_rd_p1_addr;
    assign o_dd[0] = a_if.dcd_reg_file_rd_p0_dout;
    assign o_dd[1] = a_if.dcd_reg_file_rd_p1_dout;
    assign o_ad[0] = a_if.aux_reg_file_rd_p0_dout;
    assign o_ad[1] = a_if.aux_reg_file_rd_p1_dout;

    int errors = 0;
    int checks = 0;

    // model state: how long aux has been kept waiting, and the perf count
    int          m_wait [2];
    logic [15:0] m_cnt;
    logic        e_dg [2];
    logic        e_ag [2];
    logic        e_en [2];
    logic [4:0]  e_addr [2];
    logic [31:0] e_dd [2];
    logic [31:0] e_ad [2];
    logic        e_deny [2];
    logic        e_conf;

    function automatic void model_eval();
        e_conf = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic dr, ar, c;
            dr = dreq[k] && da[k] != 0;
            ar = areq[k] && aa[k] != 0;
            c  = dr && ar && da[k] != aa[k];
            e_dg[k] = dreq[k];
            e_ag[k] = areq[k];
            if (c) begin
                if (m_wait[k] == L) e_dg[k] = 1'b0;
                else e_ag[k] = 1'b0;
            end
            e_en[k]   = (e_dg[k] && dr) || (e_ag[k] && ar);
            e_addr[k] = (e_dg[k] && dr) ? da[k] : (e_ag[k] && ar) ? aa[k] : 5'd0;
            e_dd[k]   = (e_dg[k] && dr) ? rf(da[k]) : 32'h0;
            e_ad[k]   = (e_ag[k] && ar) ? rf(aa[k]) : 32'h0;
            e_deny[k] = ar && !e_ag[k];
            e_conf    = e_conf || c;
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_wait[k] = e_deny[k] ? ((m_wait[k] + 1 > L) ? L : m_wait[k] + 1) : 0;
        m_cnt = clr ? 16'd0 : (e_conf && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            dreq[k] = 0; areq[k] = 0; da[k] = 0; aa[k] = 0;
        end
        clr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_wait[0] = 0; m_wait[1] = 0; m_cnt = 0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (a_if.perf_conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d want=0", a_if.perf_conflict_cnt);
        end
        checks++;
        if (o_en[0] !== 1'b0 || o_en[1] !== 1'b0 || o_dg[0] !== 1'b0 || o_ag[1] !== 1'b0) begin
            errors++; $display("FAIL reset_idle en=%b%b dg0=%b ag1=%b want all 0", o_en[1], o_en[0], o_dg[0], o_ag[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        m_wait[0] = 0; m_wait[1] = 0; m_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        idle_inputs();
        dreq[0] = 1; da[0] = 5;
        #1;
        checks++;
        if (o_dg[0] !== 1 || o_dd[0] !== 32'hA5A5_0005 || o_en[0] !== 1 || o_addr[0] !== 5'd5 || o_ag[0] !== 0) begin
            errors++;
            $display("FAIL single_dcd gnt=%b dout=%h en=%b addr=%0d agnt=%b want 1 a5a50005 1 5 0", o_dg[0], o_dd[0], o_en[0], o_addr[0], o_ag[0]);
        end
        tick();
    endtask

    task automatic test_zero_bypass();
        logic [15:0] c0;
        idle_inputs();
        c0 = a_if.perf_conflict_cnt;
        dreq[1] = 1; da[1] = 3; areq[1] = 1; aa[1] = 0;
        #1;
        checks++;
        if (o_dg[1] !== 1 || o_ag[1] !== 1 || o_ad[1] !== 32'h0 || o_addr[1] !== 5'd3 || o_dd[1] !== 32'hA5A5_0003) begin
            errors++;
            $display("FAIL zero_bypass dg=%b ag=%b adout=%h addr=%0d ddout=%h want 1 1 0 3 a5a50003", o_dg[1], o_ag[1], o_ad[1], o_addr[1], o_dd[1]);
        end
        tick();
        checks++;
        if (a_if.perf_conflict_cnt !== c0) begin
            errors++; $display("FAIL zero_bypass_cnt got=%0d want=%0d", a_if.perf_conflict_cnt, c0);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        idle_inputs();
        dreq[0] = 1; da[0] = 7; areq[0] = 1; aa[0] = 9;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (o_ag[0] !== (c == 4) || o_dg[0] !== (c != 4) || o_addr[0] !== ((c == 4) ? 5'd9 : 5'd7)) begin
                errors++;
                $display("FAIL starve_cycle%0d ag=%b dg=%b addr=%0d want ag=%b dg=%b", c, o_ag[0], o_dg[0], o_addr[0], c == 4, c != 4);
            end
            tick();
        end
        checks++;
        if (a_if.perf_conflict_cnt !== 16'd6) begin
            errors++; $display("FAIL starve_cnt got=%0d want=6", a_if.perf_conflict_cnt);
        end
    endtask

    task automatic test_same_addr();
        logic [15:0] c0;
        idle_inputs();
        tick();
        c0 = a_if.perf_conflict_cnt;
        for (int k = 0; k < 2; k++) begin
            dreq[k] = 1; da[k] = 12; areq[k] = 1; aa[k] = 12;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_dg[k] !== 1 || o_ag[k] !== 1 || o_dd[k] !== 32'hA5A5_000C || o_ad[k] !== 32'hA5A5_000C || o_en[k] !== 1) begin
                errors++;
                $display("FAIL same_addr_p%0d dg=%b ag=%b dd=%h ad=%h en=%b", k, o_dg[k], o_ag[k], o_dd[k], o_ad[k], o_en[k]);
            end
        end
        tick();
        checks++;
        if (a_if.perf_conflict_cnt !== c0) begin
            errors++; $display("FAIL same_addr_cnt got=%0d want=%0d", a_if.perf_conflict_cnt, c0);
        end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        dreq[0] = 1; da[0] = 7; areq[0] = 1; aa[0] = 9;
        for (int c = 0; c < 3; c++) tick();
        do_reset();
        checks++;
        if (a_if.perf_conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL midwait_cnt got=%0d want=0", a_if.perf_conflict_cnt);
        end
        tick();
        #1;
        checks++;
        if (o_dg[0] !== 1 || o_ag[0] !== 0) begin
            errors++; $display("FAIL midwait_winner dg=%b ag=%b want dg=1 ag=0", o_dg[0], o_ag[0]);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                dreq[k] = 1'($urandom_range(0, 1));
                areq[k] = 1'($urandom_range(0, 1));
                da[k]   = 5'($urandom_range(0, 3));
                aa[k]   = 5'($urandom_range(0, 3));
            end
            clr = ($urandom_range(0, 31) == 0);
            #1;
            model_eval();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_dg[k] !== e_dg[k] || o_ag[k] !== e_ag[k] || o_en[k] !== e_en[k] ||
                    o_addr[k] !== e_addr[k] || o_dd[k] !== e_dd[k] || o_ad[k] !== e_ad[k]) begin
                    errors++;
                    $display("FAIL rand%0d_p%0d got dg=%b ag=%b en=%b addr=%0d dd=%h ad=%h want %b %b %b %0d %h %h",
                             n, k, o_dg[k], o_ag[k], o_en[k], o_addr[k], o_dd[k], o_ad[k],
                             e_dg[k], e_ag[k], e_en[k], e_addr[k], e_dd[k], e_ad[k]);
                end
            end
            tick();
            checks++;
            if (a_if.perf_conflict_cnt !== m_cnt) begin
                errors++; $display("FAIL rand%0d_cnt got=%0d want=%0d", n, a_if.perf_conflict_cnt, m_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        b_if.dcd_reg_file_rd_p0_req = 1; b_if.dcd_reg_file_rd_p0_addr = 1;
        b_if.aux_reg_file_rd_p0_req = 1; b_if.aux_reg_file_rd_p0_addr = 2;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            checks++;
            if (b_if.perf_conflict_cnt !== 4'((n > 15) ? 15 : n)) begin
                errors++; $display("FAIL sat_cycle%0d got=%0d want=%0d", n, b_if.perf_conflict_cnt, (n > 15) ? 15 : n);
            end
        end
        b_if.perf_conflict_clr = 1;
        @(posedge clk); #1;
        checks++;
        if (b_if.perf_conflict_cnt !== 4'd0) begin
            errors++; $display("FAIL sat_clr got=%0d want=0", b_if.perf_conflict_cnt);
        end
        b_if.perf_conflict_clr = 0;
        b_if.dcd_reg_file_rd_p0_req = 0; b_if.aux_reg_file_rd_p0_req = 0;
    endtask

    initial begin
        idle_inputs();
        m_wait[0] = 0; m_wait[1] = 0; m_cnt = 0;
        b_if.dcd_reg_file_rd_p0_req = 0; b_if.dcd_reg_file_rd_p0_addr = 0;
        b_if.dcd_reg_file_rd_p1_req = 0; b_if.dcd_reg_file_rd_p1_addr = 0;
        b_if.aux_reg_file_rd_p0_req = 0; b_if.aux_reg_file_rd_p0_addr = 0;
        b_if.aux_reg_file_rd_p1_req = 0; b_if.aux_reg_file_rd_p1_addr = 0;
        b_if.perf_conflict_clr = 0;
        test_reset();
        test_single();
        test_zero_bypass();
        test_starvation();
        test_same_addr();
        test_reset_mid_wait();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
